// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// PC advance control for picoMIPS: runs freely, stalls on WAIT until a debounced
// button press+release, freezes on HALT. pc_inc feeds the program counter directly.
module pc_sequencer #(
   parameter int unsigned                 OPCODE_WIDTH    = 3,
   parameter logic [OPCODE_WIDTH-1:0]     WAIT_OPCODE     = OPCODE_WIDTH'(3'b110),
   parameter logic [OPCODE_WIDTH-1:0]     HALT_OPCODE     = OPCODE_WIDTH'(3'b111),
   parameter int unsigned                 DEBOUNCE_CYCLES = 4,
   parameter int unsigned                 CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                    clk,
   input  logic                    n_reset,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    button,
   output logic                    pc_inc,
   output logic                    waiting,
   output logic                    halted,
   output logic                    btn_level
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN          = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      HALT         = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q;
   logic                 stable_q, stable_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 press_q, press_d;
   logic                 release_q, release_d;
   logic                 pc_inc_c;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= RUN;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         stable_q  <= 1'b0;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= button;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Any sample matching the accepted level restarts the count, so short glitches vanish.
   always_comb begin
      stable_d  = stable_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d  = sync2_q;
         cnt_d     = '0;
         press_d   = sync2_q;
         release_d = ~sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_inc_c = 1'b0;
      case (state_q)
         RUN: begin
            if (opcode == WAIT_OPCODE) begin
               state_d = WAIT_PRESS;
            end else if (opcode == HALT_OPCODE) begin
               state_d = HALT;
            end else begin
               pc_inc_c = 1'b1;
            end
         end
         WAIT_PRESS: begin
            if (press_q) state_d = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (release_q) begin
               pc_inc_c = 1'b1;
               state_d  = RUN;
            end
         end
         HALT: state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   assign pc_inc    = n_reset & pc_inc_c;
   assign waiting   = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
   assign halted    = (state_q == HALT);
   assign btn_level = stable_q;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
// Directed bench for pc_sequencer with DEBOUNCE_CYCLES=4; outputs are checked
// 1 ns after each rising edge as {pc_inc, waiting, halted, btn_level}.
module tb_pc_sequencer;

   localparam logic [2:0] OP_WAIT = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   logic       clk;
   logic       n_reset;
   logic [2:0] opcode;
   logic       button;
   logic       pc_inc, waiting, halted, btn_level;
   logic [3:0] outs;

   int unsigned passed = 0;
   int unsigned total  = 0;

   pc_sequencer #(
      .OPCODE_WIDTH   (3),
      .WAIT_OPCODE    (3'b110),
      .HALT_OPCODE    (3'b111),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .opcode   (opcode),
      .button   (button),
      .pc_inc   (pc_inc),
      .waiting  (waiting),
      .halted   (halted),
      .btn_level(btn_level)
   );

   assign outs = {pc_inc, waiting, halted, btn_level};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      opcode  = 3'd0;
      button  = 1'b0;
      step();
      step();
      n_reset = 1'b1;
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      opcode  = 3'd0;
      button  = 1'b1;
      #1;
      total++;
      if (outs !== 4'b0000) $display("FAIL reset_comb: got %b expected %b", outs, 4'b0000);
      else passed++;
      step();
      step();
      step();
      total++;
      if (outs !== 4'b0000) $display("FAIL reset_held: got %b expected %b", outs, 4'b0000);
      else passed++;
      button  = 1'b0;
      n_reset = 1'b1;
      #1;
      total++;
      if (outs !== 4'b1000) $display("FAIL reset_release: got %b expected %b", outs, 4'b1000);
      else passed++;
   endtask

   task automatic test_run();
      for (int i = 0; i < 6; i++) begin
         opcode = 3'(i);
         #1;
         total++;
         if (outs !== 4'b1000) $display("FAIL run_op%0d: got %b expected %b", i, outs, 4'b1000);
         else passed++;
         step();
      end
   endtask

   task automatic test_wait_press_release();
      do_reset();
      opcode = OP_WAIT;
      #1;
      total++;
      if (outs !== 4'b0000) $display("FAIL wait_entry_comb: got %b expected %b", outs, 4'b0000);
      else passed++;
      step();
      total++;
      if (outs !== 4'b0100) $display("FAIL wait_entered: got %b expected %b", outs, 4'b0100);
      else passed++;
      button = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         total++;
         if (outs !== {3'b010, (k >= 6)})
            $display("FAIL wait_press_c%0d: got %b expected %b", k, outs, {3'b010, (k >= 6)});
         else passed++;
      end
      button = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         total++;
         if (outs !== ((k == 6) ? 4'b1100 : 4'b0101))
            $display("FAIL wait_release_c%0d: got %b expected %b", k, outs,
                     (k == 6) ? 4'b1100 : 4'b0101);
         else passed++;
      end
      opcode = 3'd0;
      step();
      total++;
      if (outs !== 4'b1000) $display("FAIL wait_back_to_run: got %b expected %b", outs, 4'b1000);
      else passed++;
   endtask

   task automatic test_glitch();
      logic pat [15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      opcode = OP_WAIT;
      step();
      for (int i = 0; i < 15; i++) begin
         button = pat[i];
         step();
         total++;
         if (outs !== 4'b0100) $display("FAIL glitch_c%0d: got %b expected %b", i, outs, 4'b0100);
         else passed++;
      end
      // exactly DEBOUNCE_CYCLES high is the shortest accepted press
      button = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         if (k == 5) button = 1'b0;
         step();
         total++;
         if (outs !== {3'b010, (k == 6)})
            $display("FAIL glitch_min_press_c%0d: got %b expected %b", k, outs, {3'b010, (k == 6)});
         else passed++;
      end
   endtask

   task automatic test_held();
      do_reset();
      button = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         total++;
         if (outs !== {3'b100, (k >= 6)})
            $display("FAIL held_run_c%0d: got %b expected %b", k, outs, {3'b100, (k >= 6)});
         else passed++;
      end
      opcode = OP_WAIT;
      step();
      button = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         total++;
         if (outs !== {3'b010, (k < 6)})
            $display("FAIL held_release1_c%0d: got %b expected %b", k, outs, {3'b010, (k < 6)});
         else passed++;
      end
      button = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         total++;
         if (outs !== {3'b010, (k >= 6)})
            $display("FAIL held_press_c%0d: got %b expected %b", k, outs, {3'b010, (k >= 6)});
         else passed++;
      end
      button = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         total++;
         if (outs !== ((k == 6) ? 4'b1100 : 4'b0101))
            $display("FAIL held_release2_c%0d: got %b expected %b", k, outs,
                     (k == 6) ? 4'b1100 : 4'b0101);
         else passed++;
      end
      opcode = 3'd2;
      step();
      total++;
      if (outs !== 4'b1000) $display("FAIL held_exit: got %b expected %b", outs, 4'b1000);
      else passed++;
   endtask

   task automatic test_halt();
      do_reset();
      opcode = OP_HALT;
      #1;
      total++;
      if (outs !== 4'b0000) $display("FAIL halt_comb: got %b expected %b", outs, 4'b0000);
      else passed++;
      step();
      for (int i = 0; i < 24; i++) begin
         opcode = 3'(i % 8);
         button = ((i / 6) % 2) == 1;
         step();
         total++;
         if (outs[3:1] !== 3'b001) $display("FAIL halt_c%0d: got %b expected %b", i, outs[3:1], 3'b001);
         else passed++;
      end
      button = 1'b1;
      repeat (8) step();
      n_reset = 1'b0;
      #1;
      total++;
      if (outs !== 4'b0000) $display("FAIL halt_reset: got %b expected %b", outs, 4'b0000);
      else passed++;
      opcode  = 3'd0;
      button  = 1'b0;
      n_reset = 1'b1;
      #1;
      total++;
      if (outs !== 4'b1000) $display("FAIL halt_reset_release: got %b expected %b", outs, 4'b1000);
      else passed++;
      step();
      total++;
      if (outs !== 4'b1000) $display("FAIL halt_reset_run: got %b expected %b", outs, 4'b1000);
      else passed++;
   endtask

   task automatic test_reset_wait_release();
      do_reset();
      opcode = OP_WAIT;
      step();
      button = 1'b1;
      repeat (7) step();
      total++;
      if (outs !== 4'b0101) $display("FAIL wr_reached: got %b expected %b", outs, 4'b0101);
      else passed++;
      n_reset = 1'b0;
      #1;
      total++;
      if (outs !== 4'b0000) $display("FAIL wr_reset: got %b expected %b", outs, 4'b0000);
      else passed++;
      opcode  = 3'd1;
      button  = 1'b0;
      n_reset = 1'b1;
      #1;
      total++;
      if (outs !== 4'b1000) $display("FAIL wr_reset_release: got %b expected %b", outs, 4'b1000);
      else passed++;
      step();
      total++;
      if (outs !== 4'b1000) $display("FAIL wr_reset_run: got %b expected %b", outs, 4'b1000);
      else passed++;
   endtask

   initial begin
      n_reset = 1'b0;
      opcode  = 3'd0;
      button  = 1'b0;
      step();
      test_reset();
      test_run();
      test_wait_press_release();
      test_glitch();
      test_held();
      test_halt();
      test_reset_wait_release();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
